// File: rtl/frame_buff_pingpong.sv
// Ping-pong frame store: writer fills one bank while the reader scans the other.
// Banks swap only at reader frame start with a complete frame pending.
module frame_buff_pingpong #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12,
    parameter int c_nb_ovr      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [c_nb_img_pxls-1:0] wr_addr,
    input  logic [c_nb_buf-1:0]      wr_data,
    input  logic                     wr_frame_end,
    input  logic                     rd_frame_start,
    input  logic [c_nb_img_pxls-1:0] rd_addr,
    output logic [c_nb_buf-1:0]      rd_data,
    output logic                     rd_bank,
    output logic                     frame_pending,
    output logic                     swap_pulse,
    output logic [c_nb_ovr-1:0]      overrun_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [c_nb_img_pxls-1:0] c_pxls = c_nb_img_pxls'(c_img_pxls);
    localparam logic [c_nb_ovr-1:0]      c_ovr_max = '1;

    logic [c_nb_buf-1:0] mem0_q [c_img_pxls];
    logic [c_nb_buf-1:0] mem1_q [c_img_pxls];

    logic [0:0]              state_q, state_d;
    logic                    rd_bank_q, rd_bank_d;
    logic                    swap_q, swap_d;
    logic [c_nb_ovr-1:0]     ovr_q, ovr_d;
    logic [c_nb_buf-1:0]     rd_data_q, rd_data_d;
    logic                    wr_ok;
    logic                    rd_ok;

    assign wr_ok = wr_en && (wr_addr < c_pxls);
    assign rd_ok = rd_addr < c_pxls;

    // Write bank is always the one not being read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (rd_bank_q) begin
                mem0_q[wr_addr] <= wr_data;
            end else begin
                mem1_q[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_ok) begin
            rd_data_d = rd_bank_q ? mem1_q[rd_addr] : mem0_q[rd_addr];
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        swap_d    = 1'b0;
        ovr_d     = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_frame_end && rd_frame_start) begin
                    rd_bank_d = ~rd_bank_q;
                    swap_d    = 1'b1;
                end else if (wr_frame_end) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (rd_frame_start) begin
                    rd_bank_d = ~rd_bank_q;
                    swap_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (wr_frame_end && ovr_q != c_ovr_max) begin
                    // Newest frame replaces the undisplayed one.
                    ovr_d = ovr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_bank_q <= 1'b1;
            swap_q    <= 1'b0;
            ovr_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            swap_q    <= swap_d;
            ovr_q     <= ovr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_bank       = rd_bank_q;
    assign frame_pending = (state_q == ST_PEND);
    assign swap_pulse    = swap_q;
    assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_frame_buff_pingpong.sv
// Bench for frame_buff_pingpong: directed corner sequences, a vector table
// and randomized traffic against a frame-level reference model.
module tb_frame_buff_pingpong;

    localparam int NPX  = 4800;
    localparam int NOOB = 4800;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_frame_end;
    logic        rd_frame_start;
    logic [12:0] rd_addr;
    logic [11:0] rd_data;
    logic        rd_bank;
    logic        frame_pending;
    logic        swap_pulse;
    logic [7:0]  overrun_cnt;

    frame_buff_pingpong dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_frame_end   (wr_frame_end),
        .rd_frame_start (rd_frame_start),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_bank        (rd_bank),
        .frame_pending  (frame_pending),
        .swap_pulse     (swap_pulse),
        .overrun_cnt    (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_pass = 0;

    // Reference model: two frame images, displayed index, pending flag.
    logic [11:0] mref [2][NPX];
    int m_disp, m_pend, m_ovr, m_swap, m_rd;

    typedef struct {
        logic we;
        int   wa;
        int   wd;
        logic wfe;
        logic rfs;
        int   ra;
        int   exp_rd;
        int   exp_bank;
        int   exp_swap;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_disp = 1;
        m_pend = 0;
        m_ovr  = 0;
        m_swap = 0;
        m_rd   = 0;
    endtask

    task automatic model_cycle();
        int wb;
        wb = 1 - m_disp;
        m_rd = (int'(rd_addr) < NPX) ? int'(mref[m_disp][rd_addr]) : 0;
        if (wr_en && int'(wr_addr) < NPX) mref[wb][wr_addr] = wr_data;
        m_swap = 0;
        if (rd_frame_start && (m_pend != 0 || wr_frame_end)) begin
            m_disp = 1 - m_disp;
            m_pend = 0;
            m_swap = 1;
        end else if (wr_frame_end) begin
            if (m_pend != 0 && m_ovr < 255) m_ovr++;
            m_pend = 1;
        end
    endtask

    task automatic idle();
        wr_en = 0;
        wr_addr = 0;
        wr_data = 0;
        wr_frame_end = 0;
        rd_frame_start = 0;
        rd_addr = 13'(NOOB);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".rd_data"}, int'(rd_data), m_rd);
        chk({tag, ".rd_bank"}, int'(rd_bank), m_disp);
        chk({tag, ".pending"}, int'(frame_pending), m_pend);
        chk({tag, ".swap"}, int'(swap_pulse), m_swap);
        chk({tag, ".ovr"}, int'(overrun_cnt), m_ovr);
    endtask

    task automatic fill(input int val);
        for (int a = 0; a < NPX; a++) begin
            idle();
            wr_en = 1;
            wr_addr = 13'(a);
            wr_data = 12'(val);
            step();
        end
        idle();
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1;
        #1;
        model_reset();
        chk({tag, ".rd_bank"}, int'(rd_bank), 1);
        chk({tag, ".pending"}, int'(frame_pending), 0);
        chk({tag, ".ovr"}, int'(overrun_cnt), 0);
        chk({tag, ".rd_data"}, int'(rd_data), 0);
        chk({tag, ".swap"}, int'(swap_pulse), 0);
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        tbl[0] = '{1, 4800, 'h555, 0, 0, 4799, 'h123, 1, 0};
        tbl[1] = '{1, 8191, 'h666, 0, 0, 4800, 0, 1, 0};
        tbl[2] = '{1, 4799, 'h777, 0, 0, 0, 'h123, 1, 0};
        tbl[3] = '{1, 0, 'h0F0, 0, 0, 8191, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 1, 1, 4799, 'h123, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 4799, 'h777, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 'h0F0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 1, 'hABC, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 704, 'hABC, 0, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 4095, 'hABC, 0, 0};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NPX; a++) mref[b][a] = '0;

        idle();
        rst = 1;
        model_reset();
        #1;
        chk("por.rd_bank", int'(rd_bank), 1);
        chk("por.pending", int'(frame_pending), 0);
        chk("por.ovr", int'(overrun_cnt), 0);
        chk("por.rd_data", int'(rd_data), 0);
        chk("por.swap", int'(swap_pulse), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;

        // Basic swap
        fill('hABC);
        wr_frame_end = 1;
        step();
        chk("t2.pending", int'(frame_pending), 1);
        idle();
        rd_frame_start = 1;
        step();
        chk("t2.swap", int'(swap_pulse), 1);
        chk("t2.rd_bank", int'(rd_bank), 0);
        chk("t2.pend_clr", int'(frame_pending), 0);
        idle();
        rd_addr = 17;
        step();
        chk("t2.swap_off", int'(swap_pulse), 0);
        chk("t2.rd17", int'(rd_data), 'hABC);
        cmp_all("t2");

        // No tearing
        fill('h123);
        rd_frame_start = 1;
        rd_addr = 17;
        step();
        chk("t3.noswap", int'(swap_pulse), 0);
        chk("t3.rd_bank", int'(rd_bank), 0);
        chk("t3.rd17", int'(rd_data), 'hABC);
        idle();
        rd_addr = 17;
        step();
        chk("t3.rd17b", int'(rd_data), 'hABC);

        // Overrun then mid-operation reset
        idle();
        wr_frame_end = 1;
        step();
        step();
        chk("t4.ovr1", int'(overrun_cnt), 1);
        chk("t4.pend1", int'(frame_pending), 1);
        idle();
        async_reset("t1");

        // Simultaneous events with nothing pending
        idle();
        wr_frame_end = 1;
        rd_frame_start = 1;
        step();
        chk("t5.swap", int'(swap_pulse), 1);
        chk("t5.rd_bank", int'(rd_bank), 0);
        chk("t5.pending", int'(frame_pending), 0);
        chk("t5.ovr", int'(overrun_cnt), 0);

        // Overrun saturation
        idle();
        wr_frame_end = 1;
        for (int i = 0; i < 300; i++) step();
        chk("t4.ovr_sat", int'(overrun_cnt), 255);
        chk("t4.pend", int'(frame_pending), 1);
        step();
        chk("t4.ovr_hold", int'(overrun_cnt), 255);
        idle();
        rd_frame_start = 1;
        step();
        cmp_all("t4.swap");
        chk("t4.bank", int'(rd_bank), 1);

        // Range vectors
        for (int i = 0; i < 10; i++) begin
            idle();
            wr_en = tbl[i].we;
            wr_addr = 13'(tbl[i].wa);
            wr_data = 12'(tbl[i].wd);
            wr_frame_end = tbl[i].wfe;
            rd_frame_start = tbl[i].rfs;
            rd_addr = 13'(tbl[i].ra);
            step();
            chk($sformatf("vec%0d.rd", i), int'(rd_data), tbl[i].exp_rd);
            chk($sformatf("vec%0d.bank", i), int'(rd_bank), tbl[i].exp_bank);
            chk($sformatf("vec%0d.swap", i), int'(swap_pulse), tbl[i].exp_swap);
        end
        cmp_all("t6");

        // Randomized traffic
        idle();
        async_reset("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 3) != 0);
            wr_addr = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 3) != 0) wr_addr = 13'($urandom_range(0, NPX - 1));
            wr_data = 12'($urandom);
            wr_frame_end = ($urandom_range(0, 19) == 0);
            rd_frame_start = ($urandom_range(0, 29) == 0);
            rd_addr = 13'($urandom_range(0, 4900));
            step();
            cmp_all("rnd");
        end

        idle();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
